// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding, default sizes and digit indices for the entry controller
package microwave_pkg;
  localparam int KEY_W_DEF = 4;
  localparam int MAX_SEC_TENS_DEF = 5;
  localparam int SEC_ONES = 0;
  localparam int SEC_TENS = 1;
  localparam int MIN_ONES = 2;
  localparam int MIN_TENS = 3;
  localparam int NDIG = MIN_TENS + 1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/btn_fall_edge.sv
// btn_fall_edge: one-cycle press pulse on the high-to-low transition of an active-low button level
module btn_fall_edge (
  input  logic clk,
  input  logic clr,
  input  logic lvln,
  output logic press
);
  logic prev;
  always_ff @(posedge clk or posedge clr)
    if (clr) prev <= 1'b1;
    else prev <= lvln;
  assign press = prev & ~lvln;
endmodule

// File: rtl/microwave_entry_ctrl.sv
// microwave_entry_ctrl: keypad MM:SS entry and cook control driving the countdown digit chain
module microwave_entry_ctrl
  import microwave_pkg::*;
#(
  parameter int MAX_SEC_TENS = MAX_SEC_TENS_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    key_valid,
  input  logic [KEY_W-1:0]        key_code,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic                    tick,
  input  logic                    timer_zero,
  output logic [NDIG*KEY_W-1:0]   digits,
  output logic                    loadn,
  output logic                    en,
  output logic                    mag_on,
  output logic                    done,
  output logic                    err
);
  state_t state, nxt;
  logic [NDIG*KEY_W-1:0] dig, nxt_dig, shifted;
  logic first, nxt_first, mag_q, err_q, err_nxt;
  logic start_p, stop_p, clear_p, is_digit, sec_ok;
  btn_fall_edge u_start (.clk(clk), .clr(clr), .lvln(startn), .press(start_p));
  btn_fall_edge u_stop  (.clk(clk), .clr(clr), .lvln(stopn),  .press(stop_p));
  btn_fall_edge u_clear (.clk(clk), .clr(clr), .lvln(clearn), .press(clear_p));
  assign is_digit = key_valid && (key_code < KEY_W'(10));
  assign sec_ok = dig[SEC_TENS*KEY_W +: KEY_W] <= KEY_W'(MAX_SEC_TENS);
  assign shifted = {dig[MIN_ONES*KEY_W +: KEY_W], dig[SEC_TENS*KEY_W +: KEY_W],
                    dig[SEC_ONES*KEY_W +: KEY_W], key_code};
  always_comb begin
    nxt = state;
    nxt_dig = dig;
    nxt_first = 1'b0;
    err_nxt = 1'b0;
    case (state)
      IDLE:
        if (!clear_p && is_digit) begin
          nxt_dig = shifted;
          nxt = ENTRY;
        end
      ENTRY:
        if (clear_p) begin
          nxt_dig = '0;
          nxt = IDLE;
        end else if (start_p) begin
          if (door_closed && dig != '0) begin
            nxt = sec_ok ? COOK : ENTRY;
            nxt_first = sec_ok;
            err_nxt = !sec_ok;
          end
        end else if (is_digit) nxt_dig = shifted;
      COOK:
        // the load cycle ignores timer_zero since the counters still hold stale data
        if (clear_p) begin
          nxt_dig = '0;
          nxt = IDLE;
        end else if (timer_zero && !first) nxt = DONE;
        else if (stop_p || !door_closed) nxt = PAUSE;
      PAUSE:
        if (clear_p) begin
          nxt_dig = '0;
          nxt = IDLE;
        end else if (start_p && door_closed) nxt = COOK;
      DONE:
        if (start_p || stop_p || clear_p || key_valid) begin
          nxt_dig = '0;
          nxt = IDLE;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      dig <= '0;
      first <= 1'b0;
      mag_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      dig <= nxt_dig;
      first <= nxt_first;
      mag_q <= (nxt == COOK) && !nxt_first;
      err_q <= err_nxt;
    end
  assign digits = dig;
  assign loadn = !(state == COOK && first);
  assign en = (state == COOK) && !first && tick;
  assign mag_on = mag_q;
  assign done = state == DONE;
  assign err = err_q;
endmodule
